// File: rtl/psa_reduce_seq_pkg.sv
// Shared constants, state encoding and the lane-overflow rule for the PSA
// lane-reduction unit.
//   LANE_W / LANES / DATA_W : lane geometry of the packed operands
//   ACC_W                   : signed accumulator width (range -64..+56 fits)
//   state_e                 : reduction FSM states
//   lane_ovf()              : 4-bit signed overflow of a lane add, same rule as the PSA
package psa_reduce_seq_pkg;

   localparam int unsigned LANE_W = 4;
   localparam int unsigned LANES  = 4;
   localparam int unsigned DATA_W = LANES * LANE_W;
   localparam int unsigned ACC_W  = 8;
   localparam int unsigned CNT_W  = $clog2(LANES);

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StAcc  = 2'b01,
      StDone = 2'b10
   } state_e;

   // Overflow when both operand signs agree and the wrapped sum's sign differs.
   function automatic logic lane_ovf(input logic [LANE_W-1:0] a, input logic [LANE_W-1:0] b);
      logic [LANE_W-1:0] s;
      s = a + b;
      return (a[LANE_W-1] == b[LANE_W-1]) && (s[LANE_W-1] != a[LANE_W-1]);
   endfunction

endpackage

// File: rtl/psa_reduce_seq_lane_acc_step.sv
// lane_acc_step: combinational single-lane step of the reduction.
//   a_lane, b_lane : one signed nibble from each operand
//   acc_in         : current signed accumulator
//   acc_out        : acc_in + sext(a_lane) + sext(b_lane)
//   ovf            : signed overflow of the 4-bit lane sum a_lane + b_lane
module psa_reduce_seq_lane_acc_step
   import psa_reduce_seq_pkg::*;
(
   input  logic [LANE_W-1:0] a_lane,
   input  logic [LANE_W-1:0] b_lane,
   input  logic [ACC_W-1:0]  acc_in,
   output logic [ACC_W-1:0]  acc_out,
   output logic              ovf
);

   logic [ACC_W-1:0] a_ext;
   logic [ACC_W-1:0] b_ext;

   always_comb begin
      a_ext   = {{(ACC_W-LANE_W){a_lane[LANE_W-1]}}, a_lane};
      b_ext   = {{(ACC_W-LANE_W){b_lane[LANE_W-1]}}, b_lane};
      acc_out = acc_in + a_ext + b_ext;
      ovf     = lane_ovf(a_lane, b_lane);
   end

endmodule

// File: rtl/psa_reduce_seq.sv
// psa_reduce_seq: folds all eight signed nibbles of A and B into one
// sign-extended 16-bit sum, one lane pair per cycle, and reports whether any
// lane-wise A+B would overflow 4-bit signed arithmetic.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (A, B captured on accept)
//   out_valid/out_ready : result handshake (Result, Error held under backpressure)
//   Result              : signed sum of all nibbles, sign-extended to 16 bits
//   Error               : OR of per-lane signed overflow
module psa_reduce_seq
   import psa_reduce_seq_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] Result,
   output logic              Error
);

   localparam logic [CNT_W-1:0] LastLane = CNT_W'(LANES - 1);

   state_e            state_q;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [ACC_W-1:0]  acc_q;
   logic              err_q;

   logic [LANE_W-1:0] a_lane;
   logic [LANE_W-1:0] b_lane;
   logic [ACC_W-1:0]  acc_next;
   logic              lane_err;

   always_comb begin
      a_lane = a_q[cnt_q*LANE_W +: LANE_W];
      b_lane = b_q[cnt_q*LANE_W +: LANE_W];
   end

   psa_reduce_seq_lane_acc_step u_step (
      .a_lane  (a_lane),
      .b_lane  (b_lane),
      .acc_in  (acc_q),
      .acc_out (acc_next),
      .ovf     (lane_err)
   );

   // Handshake outputs are registered, so neither in_valid nor out_ready
   // reaches in_ready/out_valid combinationally.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         Result    <= '0;
         Error     <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         cnt_q     <= '0;
         acc_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (in_valid) begin
                  a_q      <= A;
                  b_q      <= B;
                  cnt_q    <= '0;
                  acc_q    <= '0;
                  err_q    <= 1'b0;
                  in_ready <= 1'b0;
                  state_q  <= StAcc;
               end
            end
            StAcc: begin
               acc_q <= acc_next;
               err_q <= err_q | lane_err;
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == LastLane) begin
                  // Publish straight from the step output so the last lane
                  // costs no extra cycle.
                  Result    <= {{(DATA_W-ACC_W){acc_next[ACC_W-1]}}, acc_next};
                  Error     <= err_q | lane_err;
                  out_valid <= 1'b1;
                  state_q   <= StDone;
               end
            end
            StDone: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state_q   <= StIdle;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state_q   <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_psa_reduce_seq.sv
module tb_psa_reduce_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] A;
   logic [15:0] B;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] Result;
   logic        Error;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   psa_reduce_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Result    (Result),
      .Error     (Error)
   );

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
      logic        err;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%04h, expected 0x%04h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: sum of all signed nibbles as plain integers; a lane overflows
   // when its true sum leaves the 4-bit signed range.
   function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                 output logic [15:0] r, output logic e);
      int s;
      int t;
      logic [3:0] na;
      logic [3:0] nb;
      s = 0;
      e = 1'b0;
      for (int i = 0; i < 4; i++) begin
         na = a[i*4 +: 4];
         nb = b[i*4 +: 4];
         t  = int'($signed(na)) + int'($signed(nb));
         s += t;
         if (t > 7 || t < -8) e = 1'b1;
      end
      r = 16'(s);
   endfunction

   // All tasks begin and end just after a falling edge.
   task automatic send(input logic [15:0] a, input logic [15:0] b);
      int w;
      in_valid = 1'b1;
      A = a;
      B = b;
      w = 0;
      while (!in_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      n_checks++;
      if (!in_ready) begin
         n_fail++;
         $display("FAIL send_timeout: in_ready stayed 0, expected 1");
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = 1;
      while (!out_valid && lat < 30) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("after_hs_out_valid", 16'(out_valid), 16'd0);
      chk("after_hs_in_ready", 16'(in_ready), 16'd1);
   endtask

   task automatic run_check(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] er, input logic ee);
      int lat;
      send(a, b);
      wait_out(lat);
      chk({tag, "_latency"}, 16'(lat), 16'd5);
      chk({tag, "_result"}, Result, er);
      chk({tag, "_error"}, 16'(Error), 16'(ee));
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      logic [15:0] ra;
      logic [15:0] rb;
      logic [15:0] mr;
      logic        me;
      int          hold;
      int          lat;

      vecs[0] = '{16'h1234, 16'h1111, 16'h000E, 1'b0};
      vecs[1] = '{16'h8888, 16'h8888, 16'hFFC0, 1'b1};
      vecs[2] = '{16'h7000, 16'h1000, 16'h0008, 1'b1};
      vecs[3] = '{16'hF0F0, 16'h0F0F, 16'hFFFC, 1'b0};
      vecs[4] = '{16'h7777, 16'h7777, 16'h0038, 1'b1};

      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      A = '0;
      B = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("reset_in_ready", 16'(in_ready), 16'd1);
      chk("reset_out_valid", 16'(out_valid), 16'd0);
      chk("reset_result", Result, 16'd0);
      chk("reset_error", 16'(Error), 16'd0);

      // Directed table, consumer always ready.
      foreach (vecs[i]) begin
         run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].err);
         consume();
      end

      // Backpressure: result held for 3 cycles while a new request waits.
      out_ready = 1'b0;
      run_check("bp", 16'h1234, 16'h1111, 16'h000E, 1'b0);
      in_valid = 1'b1;
      A = 16'h7777;
      B = 16'h7777;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("bp_out_valid", 16'(out_valid), 16'd1);
         chk("bp_result", Result, 16'h000E);
         chk("bp_error", 16'(Error), 16'd0);
         chk("bp_in_ready", 16'(in_ready), 16'd0);
      end
      consume();
      run_check("b2b", 16'h7777, 16'h7777, 16'h0038, 1'b1);
      consume();

      // Reset at the second accumulate edge discards the partial reduction.
      send(16'h8888, 16'h8888);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_in_ready", 16'(in_ready), 16'd1);
      chk("midrst_out_valid", 16'(out_valid), 16'd0);
      chk("midrst_result", Result, 16'd0);
      chk("midrst_error", 16'(Error), 16'd0);
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk("midrst_no_stale", 16'(out_valid), 16'd0);
      end

      // Randomized against the reference model, with random backpressure.
      for (int n = 0; n < 40; n++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         if (n % 5 == 0) rb = ra;
         model(ra, rb, mr, me);
         hold = int'($urandom_range(0, 3));
         out_ready = (hold == 0);
         send(ra, rb);
         wait_out(lat);
         chk("rnd_latency", 16'(lat), 16'd5);
         chk("rnd_result", Result, mr);
         chk("rnd_error", 16'(Error), 16'(me));
         for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            chk("rnd_hold_valid", 16'(out_valid), 16'd1);
            chk("rnd_hold_result", Result, mr);
         end
         consume();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
